approx_mult_iter: RTL and testbench

//  Parametrised iterative unsigned WIDTHxWIDTH multiplier built from 4x4 tiles, one tile per cycle.

---
 rtl/approx_mult_pkg.sv | 20 ++
 rtl/approx_tile_4x4.sv | 57 +++++
 rtl/approx_mult_iter.sv | 127 ++++++++++++
 tb/tb_approx_mult_iter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the iterative approximate multiplier.
//   TILE_W        : width of one operand nibble handled by a tile
//   MODE_*        : transaction mode encodings (reserved behaves as exact)
//   state_e       : control FSM states
package approx_mult_pkg;

    localparam int unsigned TILE_W = 4;

    localparam logic [1:0] MODE_EXACT  = 2'b00;
    localparam logic [1:0] MODE_APPROX = 2'b01;
    localparam logic [1:0] MODE_HYBRID = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/approx_tile_4x4.sv
// Combinational 4x4 unsigned multiplier tile, exact or compressor-based approximate.
//   a_i, b_i     : 4-bit operands
//   approx_en_i  : 1 selects the approximate partial-product reduction
//   p_o          : 8-bit product
module approx_tile_4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       approx_en_i,
    output logic [7:0] p_o
);

    logic [3:0] pp [4];  // pp[x][y] = a[x] & b[y]
    logic       pr12, g02, pr13, g13, pr03, pr23, g23;
    logic       c3, s3, c4, s4, c6, c7, c8;
    logic [1:0] sum3, sum4, sum5, sum6;
    logic [7:0] approx_p;
    logic [7:0] exact_p;

    always_comb begin
        for (int x = 0; x < 4; x++) begin
            pp[x] = {4{a_i[x]}} & b_i;
        end

        // Symmetric pairs are merged: OR keeps one weight, AND carries the overlap.
        pr12 = pp[1][2] | pp[2][1];
        g02  = pp[0][2] & pp[2][0];
        pr13 = pp[1][3] | pp[3][1];
        g13  = pp[1][3] & pp[3][1];
        pr03 = pp[0][3] | pp[3][0];
        pr23 = pp[2][3] | pp[3][2];
        g23  = pp[2][3] & pp[3][2];

        c6 = pr12 & g02;

        sum3 = 2'(pp[2][2]) + 2'(pr13) + 2'(g13);
        c3   = sum3[1];
        s3   = sum3[0];

        sum4 = 2'(s3) + 2'(pr03) + 2'(c6);
        c7   = sum4[1];

        s4 = pr23 ^ g23;
        c4 = pr23 & g23;

        sum5 = 2'(s4) + 2'(c3) + 2'(c7);
        c8   = sum5[1];

        sum6 = 2'(pp[3][3]) + 2'(c4) + 2'(c8);

        approx_p = {sum6, sum5[0], sum4[0], pr12 ^ g02, pp[1][1],
                    pp[1][0] | pp[0][1], pp[0][0]};
        exact_p  = 8'(a_i) * 8'(b_i);

        p_o = approx_en_i ? approx_p : exact_p;
    end

endmodule

// File: rtl/approx_mult_iter.sv
// Iterative WIDTHxWIDTH unsigned multiplier, one 4x4 tile per clock.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid_i     : operand request        in_ready_o : operands can be accepted
//   in_a_i, in_b_i : operands               in_mode_i  : 00 exact, 01 approx, 10 hybrid, 11 exact
//   out_valid_o    : product valid          out_ready_i: consumer takes product
//   out_p_o        : 2*WIDTH-bit product    out_approx_o: some tile was approximate
// WIDTH must be a non-zero multiple of 4. Product appears NT*NT cycles after acceptance.
module approx_mult_iter
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_DIAG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    input  logic [1:0]           in_mode_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   out_p_o,
    output logic                 out_approx_o
);

    localparam int unsigned NT    = WIDTH / TILE_W;
    localparam int unsigned T     = NT * NT;
    localparam int unsigned CntW  = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned ProdW = 2 * WIDTH;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [1:0]        mode_q;
    logic [ProdW-1:0]  acc_q;
    logic              approx_q;
    logic              out_valid_q;

    logic              accept;
    logic [CntW-1:0]   i_idx, j_idx;
    int unsigned       tile_pos;
    logic [WIDTH-1:0]  a_shift, b_shift;
    logic [TILE_W-1:0] a_nib, b_nib;
    logic              tile_approx;
    logic [7:0]        tile_p;
    logic [ProdW-1:0]  tile_shifted;

    assign in_ready_o = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        // cnt walks B nibbles fastest: cnt = i*NT + j
        i_idx    = cnt_q / CntW'(NT);
        j_idx    = cnt_q % CntW'(NT);
        tile_pos = 32'(i_idx) + 32'(j_idx);

        a_shift = a_q >> (TILE_W * 32'(i_idx));
        b_shift = b_q >> (TILE_W * 32'(j_idx));
        a_nib   = a_shift[TILE_W-1:0];
        b_nib   = b_shift[TILE_W-1:0];

        tile_approx = 1'b0;
        case (mode_q)
            MODE_APPROX:           tile_approx = 1'b1;
            MODE_HYBRID:           tile_approx = (tile_pos < APPROX_DIAG);
            MODE_EXACT, MODE_RSVD: tile_approx = 1'b0;
            default:               tile_approx = 1'b0;
        endcase

        tile_shifted = ProdW'(tile_p) << (TILE_W * tile_pos);
    end

    approx_tile_4x4 u_tile (
        .a_i         (a_nib),
        .b_i         (b_nib),
        .approx_en_i (tile_approx),
        .p_o         (tile_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_EXACT;
            acc_q       <= '0;
            approx_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            // Covers both the idle accept and the back-to-back accept from DONE.
            state_q     <= StBusy;
            cnt_q       <= '0;
            a_q         <= in_a_i;
            b_q         <= in_b_i;
            mode_q      <= in_mode_i;
            acc_q       <= '0;
            approx_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StBusy: begin
                    acc_q    <= acc_q + tile_shifted;
                    approx_q <= approx_q | tile_approx;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(T - 1)) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_p_o      = acc_q;
    assign out_approx_o = approx_q;

endmodule

// File: tb/tb_approx_mult_iter.sv
module tb_approx_mult_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] p;
        bit          apx;
    } exp_t;
    exp_t sb_q[$];

    // W=8, APPROX_DIAG=1
    logic        iv8, ir8, ov8, or8, ap8;
    logic [7:0]  a8, b8;
    logic [1:0]  m8;
    logic [15:0] p8;
    // W=4, APPROX_DIAG=1
    logic        iv4, ir4, ov4, or4, ap4;
    logic [3:0]  a4, b4;
    logic [1:0]  m4;
    logic [7:0]  p4;
    // W=16, APPROX_DIAG=3
    logic        iv16, ir16, ov16, or16, ap16;
    logic [15:0] a16, b16;
    logic [1:0]  m16;
    logic [31:0] p16;

    approx_mult_iter #(.WIDTH(8), .APPROX_DIAG(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv8), .in_ready_o(ir8), .in_a_i(a8), .in_b_i(b8),
        .in_mode_i(m8), .out_valid_o(ov8), .out_ready_i(or8), .out_p_o(p8), .out_approx_o(ap8)
    );
    approx_mult_iter #(.WIDTH(4), .APPROX_DIAG(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv4), .in_ready_o(ir4), .in_a_i(a4), .in_b_i(b4),
        .in_mode_i(m4), .out_valid_o(ov4), .out_ready_i(or4), .out_p_o(p4), .out_approx_o(ap4)
    );
    approx_mult_iter #(.WIDTH(16), .APPROX_DIAG(3)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv16), .in_ready_o(ir16), .in_a_i(a16),
        .in_b_i(b16), .in_mode_i(m16), .out_valid_o(ov16), .out_ready_i(or16), .out_p_o(p16),
        .out_approx_o(ap16)
    );

    // Reference approximate/exact 4x4 tile, written from the bit-level rule.
    function automatic logic [7:0] tile_model(input logic [3:0] a, input logic [3:0] b,
                                              input bit apx);
        int pv [4][4];
        int pr12, g02, pr13, g13, pr03, pr23, g23;
        int t3, t4, t5, t6, c3, s3, c6, c7, s4, c4, c8, r;
        if (!apx) return 8'(32'(a) * 32'(b));
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                pv[x][y] = (a[x] && b[y]) ? 1 : 0;
        pr12 = pv[1][2] | pv[2][1];  g02 = pv[0][2] & pv[2][0];
        pr13 = pv[1][3] | pv[3][1];  g13 = pv[1][3] & pv[3][1];
        pr03 = pv[0][3] | pv[3][0];
        pr23 = pv[2][3] | pv[3][2];  g23 = pv[2][3] & pv[3][2];
        c6 = pr12 & g02;
        t3 = pv[2][2] + pr13 + g13;  c3 = t3 / 2;  s3 = t3 % 2;
        t4 = s3 + pr03 + c6;         c7 = t4 / 2;
        s4 = pr23 ^ g23;             c4 = pr23 & g23;
        t5 = s4 + c3 + c7;           c8 = t5 / 2;
        t6 = pv[3][3] + c4 + c8;
        r = pv[0][0] + 2 * (pv[1][0] | pv[0][1]) + 4 * pv[1][1] + 8 * (pr12 ^ g02)
            + 16 * (t4 % 2) + 32 * (t5 % 2) + 64 * t6;
        return 8'(r);
    endfunction

    function automatic exp_t model_prod(input longint unsigned a, input longint unsigned b,
                                        input int w, input int mode, input int diag);
        exp_t e;
        longint unsigned acc = 0;
        bit apx = 0;
        int nt = w / 4;
        for (int i = 0; i < nt; i++) begin
            for (int j = 0; j < nt; j++) begin
                bit t;
                logic [3:0] an, bn;
                t  = (mode == 1) || (mode == 2 && (i + j) < diag);
                an = 4'(a >> (4 * i));
                bn = 4'(b >> (4 * j));
                acc += longint'(tile_model(an, bn, t)) << (4 * (i + j));
                apx |= t;
            end
        end
        e.p = 32'(acc);
        e.apx = apx;
        return e;
    endfunction

    // Drive one operand beat into the W=8 block; caller guarantees in_ready.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        a8 = a; b8 = b; m8 = m; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    // Counts edges until out_valid (bounded); cyc hitting 64 means no product arrived.
    task automatic wait8(output int cyc);
        cyc = 0;
        while (ov8 !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic consume8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov8); end
        checks++; if (p8 !== 16'd0) begin errors++; $display("FAIL reset_out_p: got %0d expected 0", p8); end
        checks++; if (ap8 !== 1'b0) begin errors++; $display("FAIL reset_out_approx: got %b expected 0", ap8); end
        checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir8); end
        checks++; if (ir4 !== 1'b1 || ir16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_w4_w16: got %b%b expected 11", ir4, ir16); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b valid=%b expected 1/0", ir8, ov8); end
    endtask

    task automatic test_vectors();
        logic [7:0] ta [8] = '{8'd15, 8'd15, 8'd255, 8'd255, 8'd255, 8'd255, 8'd3, 8'd2};
        logic [7:0] tb [8] = '{8'd15, 8'd15, 8'd255, 8'd255, 8'd255, 8'd255, 8'd3, 8'd2};
        logic [1:0] tm [8] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1};
        int         tp [8] = '{215, 225, 65025, 62135, 65015, 65025, 7, 4};
        bit         tx [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            int cyc;
            e.p = 32'(tp[k]); e.apx = tx[k];
            sb_q.push_back(e);
            send8(ta[k], tb[k], tm[k]);
            wait8(cyc);
            e = sb_q.pop_front();
            checks++; if (cyc != 4) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 4", k, cyc); end
            checks++; if (p8 !== e.p[15:0]) begin errors++; $display("FAIL vec%0d_product: got %0d expected %0d", k, p8, e.p[15:0]); end
            checks++; if (ap8 !== e.apx) begin errors++; $display("FAIL vec%0d_approx: got %b expected %b", k, ap8, e.apx); end
            consume8();
        end
    endtask

    task automatic test_backpressure();
        exp_t e, e2;
        int cyc;
        e.p = 32'd65025; e.apx = 1'b0;
        sb_q.push_back(e);
        send8(8'd255, 8'd255, 2'd0);
        wait8(cyc);
        e = sb_q.pop_front();
        checks++; if (cyc != 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", cyc); end
        // New operands offered while the consumer stalls must be ignored.
        a8 = 8'd12; b8 = 8'd10; m8 = 2'd1; iv8 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++; if (p8 !== e.p[15:0] || ov8 !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got p=%0d valid=%b expected p=%0d valid=1", k, p8, ov8, e.p[15:0]); end
            checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b expected 0", k, ir8); end
            @(posedge clk); #1;
        end
        sb_q.push_back(model_prod(12, 10, 8, 1, 1));
        or8 = 1'b1;
        #1;
        checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", ir8); end
        @(posedge clk); #1;
        or8 = 1'b0; iv8 = 1'b0;
        checks++; if (ov8 !== 1'b0 || ir8 !== 1'b0) begin errors++; $display("FAIL b2b_accept: got valid=%b ready=%b expected 0/0", ov8, ir8); end
        wait8(cyc);
        e2 = sb_q.pop_front();
        checks++; if (cyc != 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", cyc); end
        checks++; if (p8 !== e2.p[15:0] || ap8 !== e2.apx) begin errors++; $display("FAIL b2b_product: got %0d/%b expected %0d/%b", p8, ap8, e2.p[15:0], e2.apx); end
        consume8();
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        int cyc;
        send8(8'd200, 8'd100, 2'd0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin errors++; $display("FAIL midreset_flags: got valid=%b ready=%b expected 0/1", ov8, ir8); end
        checks++; if (p8 !== 16'd0 || ap8 !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got %0d/%b expected 0/0", p8, ap8); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        e.p = 32'd120; e.apx = 1'b0;
        sb_q.push_back(e);
        send8(8'd12, 8'd10, 2'd0);
        wait8(cyc);
        e = sb_q.pop_front();
        checks++; if (cyc != 4 || p8 !== e.p[15:0] || ap8 !== e.apx) begin errors++; $display("FAIL post_reset_txn: got %0d/%b after %0d expected %0d/%b after 4", p8, ap8, cyc, e.p[15:0], e.apx); end
        consume8();
    endtask

    task automatic test_random_exact();
        for (int n = 0; n < 3000; n++) begin
            exp_t e;
            int cyc;
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            e.p = 32'(a) * 32'(b); e.apx = 1'b0;
            sb_q.push_back(e);
            send8(a, b, (n % 2 == 0) ? 2'd0 : 2'd3);
            wait8(cyc);
            e = sb_q.pop_front();
            checks++; if (cyc >= 64 || p8 !== e.p[15:0] || ap8 !== 1'b0) begin errors++; $display("FAIL rand_exact %0d*%0d: got %0d/%b expected %0d/0", a, b, p8, ap8, e.p[15:0]); end
            consume8();
        end
    endtask

    task automatic test_width4();
        for (int m = 0; m < 3; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    exp_t e;
                    int cyc;
                    sb_q.push_back(model_prod(a, b, 4, m, 1));
                    a4 = 4'(a); b4 = 4'(b); m4 = 2'(m); iv4 = 1'b1;
                    @(posedge clk); #1;
                    iv4 = 1'b0;
                    cyc = 0;
                    while (ov4 !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
                    e = sb_q.pop_front();
                    checks++; if (cyc != 1 || p4 !== e.p[7:0] || ap4 !== e.apx) begin errors++; $display("FAIL w4 mode%0d %0d*%0d: got %0d/%b after %0d expected %0d/%b after 1", m, a, b, p4, ap4, cyc, e.p[7:0], e.apx); end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_width16();
        for (int n = 0; n < 200; n++) begin
            exp_t e;
            int cyc, m;
            logic [15:0] a, b;
            a = (n < 4) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            b = (n < 4) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            m = (n < 4) ? n : int'($urandom_range(0, 3));
            sb_q.push_back(model_prod(a, b, 16, m, 3));
            a16 = a; b16 = b; m16 = 2'(m); iv16 = 1'b1;
            @(posedge clk); #1;
            iv16 = 1'b0;
            cyc = 0;
            while (ov16 !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
            e = sb_q.pop_front();
            checks++; if (cyc != 16 || p16 !== e.p || ap16 !== e.apx) begin errors++; $display("FAIL w16 mode%0d %0d*%0d: got %0d/%b after %0d expected %0d/%b after 16", m, a, b, p16, ap16, cyc, e.p, e.apx); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        iv8 = 1'b0; a8 = '0; b8 = '0; m8 = '0; or8 = 1'b0;
        iv4 = 1'b0; a4 = '0; b4 = '0; m4 = '0; or4 = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; m16 = '0; or16 = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_midflight();
        test_random_exact();
        test_width4();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
